// File: rtl/io_out_arbiter.sv
// Round-robin arbiter sharing the user-project GPIO output bank between NREQ requesters.
// Every committed out/oeb value is held for HOLD_CYCLES extra cycles before the next grant.
//
// state | meaning
// IDLE  | grant the next valid requester (round-robin after grant_id)
// HOLD  | committed value held stable, no grants while hold_cnt counts down
module io_out_arbiter #(
    parameter int NREQ        = 2,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    input  logic [NREQ*WIDTH-1:0]      req_oeb,
    output logic [NREQ-1:0]            req_ready,
    output logic [WIDTH-1:0]           io_out,
    output logic [WIDTH-1:0]           io_oeb,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       busy,
    output logic [15:0]                update_count
);

    localparam int IDW   = $clog2(NREQ);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0]   io_out_q, io_out_d;
    logic [WIDTH-1:0]   io_oeb_q, io_oeb_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic               busy_q, busy_d;
    logic [15:0]        update_count_q, update_count_d;

    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic [IDW-1:0]     cand;
    logic               xfer;

    // Search starts just after the last winner, so a continuously valid
    // requester waits at most NREQ-1 grants.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(grant_id_q) + 1 + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign xfer      = (state_q == IDLE) && win_found && !wb_rst_i;
    assign req_ready = xfer ? (NREQ'(1) << win_idx) : '0;

    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        io_out_d       = io_out_q;
        io_oeb_d       = io_oeb_q;
        grant_id_d     = grant_id_q;
        busy_d         = busy_q;
        update_count_d = update_count_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    io_out_d       = req_data[int'(win_idx)*WIDTH +: WIDTH];
                    io_oeb_d       = req_oeb[int'(win_idx)*WIDTH +: WIDTH];
                    grant_id_d     = win_idx;
                    update_count_d = update_count_q + 16'd1;
                    if (HOLD_CYCLES > 0) begin
                        state_d    = HOLD;
                        hold_cnt_d = HOLD_LOAD;
                        busy_d     = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q        <= IDLE;
            hold_cnt_q     <= '0;
            io_out_q       <= '0;
            io_oeb_q       <= '1;
            grant_id_q     <= IDW'(NREQ - 1);
            busy_q         <= 1'b0;
            update_count_q <= '0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            io_out_q       <= io_out_d;
            io_oeb_q       <= io_oeb_d;
            grant_id_q     <= grant_id_d;
            busy_q         <= busy_d;
            update_count_q <= update_count_d;
        end
    end

    assign io_out       = io_out_q;
    assign io_oeb       = io_oeb_q;
    assign grant_id     = grant_id_q;
    assign busy         = busy_q;
    assign update_count = update_count_q;

endmodule

// File: tb/tb_io_out_arbiter.sv
// Directed bench: u_dut4 uses HOLD_CYCLES=4, u_dut0 uses HOLD_CYCLES=0.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_io_out_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  v4, v0;
    logic [15:0] d4, o4, d0, o0;
    logic [1:0]  r4, r0;
    logic [7:0]  io4, oeb4, io0, oeb0;
    logic        g4, g0, b4, b0;
    logic [15:0] cnt4, cnt0;

    int cyc = 0;
    int n_pass = 0;
    int n_chk = 0;
    int last_acc = 0;
    bit got;

    logic [7:0] vals [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                              8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    io_out_arbiter #(.NREQ(2), .WIDTH(8), .HOLD_CYCLES(4)) u_dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(v4), .req_data(d4), .req_oeb(o4),
        .req_ready(r4), .io_out(io4), .io_oeb(oeb4), .grant_id(g4), .busy(b4),
        .update_count(cnt4)
    );

    io_out_arbiter #(.NREQ(2), .WIDTH(8), .HOLD_CYCLES(0)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(v0), .req_data(d0), .req_oeb(o0),
        .req_ready(r0), .io_out(io0), .io_oeb(oeb0), .grant_id(g0), .busy(b0),
        .update_count(cnt0)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            samp();
            if (!b4) ok = 1'b1;
            else step();
        end
        chk(tag, 32'(ok), 1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; v4 = 2'b11; v0 = 2'b00;
        d4 = 16'h0; o4 = 16'h0; d0 = 16'h0; o0 = 16'h0;

        // reset with requests pending
        for (int i = 0; i < 3; i++) begin
            samp();
            chk("t1_ready_in_reset", 32'(r4), 0);
            step();
        end
        rst = 1'b0; v4 = 2'b00;
        samp();
        chk("t1_io_out", 32'(io4), 32'h00);
        chk("t1_io_oeb", 32'(oeb4), 32'hFF);
        chk("t1_grant_id", 32'(g4), 1);
        chk("t1_busy", 32'(b4), 0);
        chk("t1_count", 32'(cnt4), 0);
        step();

        // single requester stream
        v4 = 2'b01; o4 = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            d4[7:0] = vals[i];
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                samp();
                if (r4[0]) got = 1'b1;
                else begin
                    if (i > 0) chk("t2_hold", 32'(io4), 32'(vals[i-1]));
                    step();
                end
            end
            chk("t2_accept", 32'(got), 1);
            if (i > 0) chk("t2_spacing", cyc - last_acc, 5);
            last_acc = cyc;
            step();
            chk("t2_io_out", 32'(io4), 32'(vals[i]));
            chk("t2_io_oeb", 32'(oeb4), 32'h00);
        end
        v4 = 2'b00;
        chk("t2_count", 32'(cnt4), 12);

        // both continuously valid after a reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        v4 = 2'b11; d4 = 16'h5AA5;
        for (int i = 0; i < 4; i++) begin
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                samp();
                if (r4 != 2'b00) got = 1'b1;
                else step();
            end
            chk("t3_accept", 32'(got), 1);
            chk("t3_ready", 32'(r4), (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i > 0) chk("t3_spacing", cyc - last_acc, 5);
            last_acc = cyc;
            step();
            chk("t3_grant_id", 32'(g4), 32'(i % 2));
            chk("t3_io_out", 32'(io4), (i % 2 == 0) ? 32'hA5 : 32'h5A);
        end
        v4 = 2'b00;

        // requester 1 arrives one cycle into HOLD
        wait_idle("t4_idle");
        v4 = 2'b01; d4 = 16'hC33C;
        samp();
        chk("t4_ready0", 32'(r4), 32'h1);
        step();
        v4 = 2'b10;
        for (int i = 0; i < 4; i++) begin
            samp();
            chk("t4_ready_hold", 32'(r4), 0);
            chk("t4_io_stable", 32'(io4), 32'h3C);
            step();
        end
        samp();
        chk("t4_ready1", 32'(r4), 32'h2);
        step();
        v4 = 2'b00;
        chk("t4_io_out", 32'(io4), 32'hC3);
        chk("t4_grant_id", 32'(g4), 1);

        // reset during HOLD
        wait_idle("t5_idle");
        v4 = 2'b01; d4 = 16'h0007;
        samp();
        chk("t5_ready0", 32'(r4), 32'h1);
        step();
        chk("t5_busy", 32'(b4), 1);
        chk("t5_io_out", 32'(io4), 32'h07);
        rst = 1'b1;
        samp();
        chk("t5_ready_in_reset", 32'(r4), 0);
        step();
        rst = 1'b0;
        chk("t5_rst_io_out", 32'(io4), 32'h00);
        chk("t5_rst_io_oeb", 32'(oeb4), 32'hFF);
        chk("t5_rst_busy", 32'(b4), 0);
        chk("t5_rst_count", 32'(cnt4), 0);
        v4 = 2'b11; d4 = 16'h2211;
        samp();
        chk("t5_first_grant", 32'(r4), 32'h1);
        step();
        v4 = 2'b00;
        chk("t5_grant_id", 32'(g4), 0);
        chk("t5_io_after", 32'(io4), 32'h11);

        // HOLD_CYCLES=0: back-to-back updates
        v0 = 2'b01; o0 = 16'h0000; d0 = 16'h0011;
        samp();
        chk("t6_ready_a", 32'(r0), 32'h1);
        chk("t6_busy_a", 32'(b0), 0);
        step();
        chk("t6_io_a", 32'(io0), 32'h11);
        d0 = 16'h0022;
        samp();
        chk("t6_ready_b", 32'(r0), 32'h1);
        chk("t6_busy_b", 32'(b0), 0);
        step();
        chk("t6_io_b", 32'(io0), 32'h22);
        d0 = 16'h0033;
        samp();
        chk("t6_ready_c", 32'(r0), 32'h1);
        step();
        v0 = 2'b00;
        chk("t6_io_c", 32'(io0), 32'h33);
        chk("t6_busy_c", 32'(b0), 0);
        chk("t6_count", 32'(cnt0), 3);

        // update_count wrap
        samp();
        force u_dut0.update_count_q = 16'hFFFF;
        #1;
        release u_dut0.update_count_q;
        chk("t6_count_preset", 32'(cnt0), 32'hFFFF);
        v0 = 2'b01; d0 = 16'h0044;
        step();
        v0 = 2'b00;
        chk("t6_count_wrap", 32'(cnt0), 32'h0000);
        chk("t6_io_wrap", 32'(io0), 32'h44);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
